// File: rtl/ram36k_port_arbiter_if.sv
// ============================================================================
// ram36k_port_arbiter_if : requester command/response bus plus RAM port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface ram36k_port_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [1:0]  req_lock;
  logic [19:0] req_addr;
  logic [7:0]  req_be;
  logic [63:0] req_wdata;
  logic [7:0]  req_wparity;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_rparity;
  logic        ram_wen;
  logic        ram_ren;
  logic [14:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wparity;
  logic [31:0] ram_rdata;
  logic [3:0]  ram_rparity;
  logic        busy;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_be, req_wdata, req_wparity,
    input  ram_rdata, ram_rparity,
    output req_ready, rsp_valid, rsp_rdata, rsp_rparity,
    output ram_wen, ram_ren, ram_addr, ram_be, ram_wdata, ram_wparity, busy
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_be, req_wdata, req_wparity,
    output ram_rdata, ram_rparity,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rparity,
    input  ram_wen, ram_ren, ram_addr, ram_be, ram_wdata, ram_wparity, busy
  );
endinterface

`default_nettype wire

// File: rtl/ram36k_port_arbiter.sv
// ============================================================================
// ram36k_port_arbiter : two-requester round-robin arbiter with lock for one
//                       36-bit RAM port, with in-order read response routing
// Rev 1.0
// ============================================================================
`default_nettype none

module ram36k_port_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  ram36k_port_arbiter_if.slave  bus
);

  localparam int c_TAG_DEPTH = 1 + READ_LATENCY;

  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_read_latency
    $error("ram36k_port_arbiter: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_pri;
  logic [1:0]        w_ready;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_id;

  logic [9:0]        w_addr;
  logic              w_we;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wparity;

  logic              r_ram_wen;
  logic              r_ram_ren;
  logic [14:0]       r_ram_addr;
  logic [3:0]        r_ram_be;
  logic [31:0]       r_ram_wdata;
  logic [3:0]        r_ram_wparity;

  logic [c_TAG_DEPTH-1:0] r_tag_vld;
  logic [c_TAG_DEPTH-1:0] r_tag_id;

  // Grants are one-hot by construction, so the granted id is simply bit 1.
  always_comb begin
    w_ready     = 2'b00;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid == 2'b11) begin
          w_ready = r_pri ? 2'b10 : 2'b01;
        end else begin
          w_ready = bus.req_valid;
        end
      end
      S_OWN0:  w_ready = {1'b0, bus.req_valid[0]};
      S_OWN1:  w_ready = {bus.req_valid[1], 1'b0};
      default: w_ready = 2'b00;
    endcase
    if (rst) begin
      w_ready = 2'b00;
    end
    w_grant  = w_ready & bus.req_valid;
    w_accept = |w_grant;
    w_id     = w_grant[1];
    if (w_accept) begin
      w_state_nxt = bus.req_lock[w_id] ? (w_id ? S_OWN1 : S_OWN0) : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pri   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pri <= ~w_id;
      end
    end
  end

  assign w_addr    = w_id ? bus.req_addr[19:10]    : bus.req_addr[9:0];
  assign w_we      = w_id ? bus.req_we[1]          : bus.req_we[0];
  assign w_be      = w_id ? bus.req_be[7:4]        : bus.req_be[3:0];
  assign w_wdata   = w_id ? bus.req_wdata[63:32]   : bus.req_wdata[31:0];
  assign w_wparity = w_id ? bus.req_wparity[7:4]   : bus.req_wparity[3:0];

  // Strobes fall back to zero every idle cycle; address and data only move on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_wen     <= 1'b0;
      r_ram_ren     <= 1'b0;
      r_ram_be      <= 4'b0;
      r_ram_addr    <= 15'b0;
      r_ram_wdata   <= 32'b0;
      r_ram_wparity <= 4'b0;
    end else begin
      r_ram_wen <= w_accept & w_we;
      r_ram_ren <= w_accept & ~w_we;
      r_ram_be  <= (w_accept & w_we) ? w_be : 4'b0;
      if (w_accept) begin
        r_ram_addr    <= {w_addr, 5'b0};
        r_ram_wdata   <= w_wdata;
        r_ram_wparity <= w_wparity;
      end
    end
  end

  // Stage k describes the read issued to the RAM k cycles ago; the last stage lines up with RDATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[c_TAG_DEPTH-2:0], w_accept & ~w_we};
      r_tag_id  <= {r_tag_id[c_TAG_DEPTH-2:0], w_id};
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.rsp_valid   = r_tag_vld[c_TAG_DEPTH-1]
                         ? (r_tag_id[c_TAG_DEPTH-1] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata   = bus.ram_rdata;
  assign bus.rsp_rparity = bus.ram_rparity;

  assign bus.ram_wen     = r_ram_wen;
  assign bus.ram_ren     = r_ram_ren;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_be      = r_ram_be;
  assign bus.ram_wdata   = r_ram_wdata;
  assign bus.ram_wparity = r_ram_wparity;

  assign bus.busy        = (r_state != S_IDLE) | (|r_tag_vld);

endmodule

`default_nettype wire

// File: tb/tb_ram36k_port_arbiter.sv
// Bench: two arbiters (READ_LATENCY 1 and 2) share one stimulus stream, each
// driving its own RAM model; responses are scoreboarded against a reference memory.
`default_nettype none
`timescale 1ns/1ps

module tb_ram36k_port_arbiter;

  typedef struct {
    int          id;
    int          due;
    logic [31:0] data;
    logic [3:0]  par;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_lock;
  logic [19:0] req_addr;
  logic [7:0]  req_be;
  logic [63:0] req_wdata;
  logic [7:0]  req_wparity;

  logic [1:0]  dut_ready [2];
  logic [1:0]  dut_rsp_valid [2];
  logic        dut_wen [2];
  logic        dut_ren [2];
  logic        dut_busy [2];
  logic [3:0]  dut_be [2];
  logic [3:0]  dut_wpar [2];
  logic [3:0]  dut_rpar [2];
  logic [14:0] dut_addr [2];
  logic [31:0] dut_wdata [2];
  logic [31:0] dut_rdata [2];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // reference model state
  int          owner   = -1;
  bit          pri     = 1'b0;
  int          last_rd = -100;
  logic [35:0] refmem [1024] = '{default: '0};
  logic        e_wen = 1'b0, e_ren = 1'b0;
  logic [3:0]  e_be = 4'b0, e_wpar = 4'b0;
  logic [14:0] e_addr = 15'b0;
  logic [31:0] e_wdata = 32'b0;
  rsp_t        q0 [$];
  rsp_t        q1 [$];
  int          grant_log [$];
  logic [31:0] last_rsp [2];
  logic [14:0] last_addr;

  int exp_alt  [6] = '{0, 1, 0, 1, 0, 1};
  int exp_lock [6] = '{1, -1, -1, -1, 1, 0};

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ram36k_port_arbiter_if bus ();
    logic [35:0] mem [1024] = '{default: '0};
    logic [35:0] rd1 = '0;
    logic [35:0] rd2 = '0;

    assign bus.req_valid   = req_valid;
    assign bus.req_we      = req_we;
    assign bus.req_lock    = req_lock;
    assign bus.req_addr    = req_addr;
    assign bus.req_be      = req_be;
    assign bus.req_wdata   = req_wdata;
    assign bus.req_wparity = req_wparity;
    assign bus.ram_rdata   = (k == 0) ? rd1[31:0]  : rd2[31:0];
    assign bus.ram_rparity = (k == 0) ? rd1[35:32] : rd2[35:32];

    assign dut_ready[k]     = bus.req_ready;
    assign dut_rsp_valid[k] = bus.rsp_valid;
    assign dut_wen[k]       = bus.ram_wen;
    assign dut_ren[k]       = bus.ram_ren;
    assign dut_busy[k]      = bus.busy;
    assign dut_be[k]        = bus.ram_be;
    assign dut_wpar[k]      = bus.ram_wparity;
    assign dut_rpar[k]      = bus.rsp_rparity;
    assign dut_addr[k]      = bus.ram_addr;
    assign dut_wdata[k]     = bus.ram_wdata;
    assign dut_rdata[k]     = bus.rsp_rdata;

    // RAM port model: byte-enabled write, reads registered once per latency cycle
    always @(posedge clk) begin
      if (bus.ram_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_be[b]) begin
            mem[bus.ram_addr[14:5]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            mem[bus.ram_addr[14:5]][32+b]     <= bus.ram_wparity[b];
          end
        end
      end
      if (bus.ram_ren) rd1 <= mem[bus.ram_addr[14:5]];
      rd2 <= rd1;
    end

    ram36k_port_arbiter #(.READ_LATENCY(k + 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [1:0] exp_ready();
    if (rst) return 2'b00;
    if (owner == 0) return {1'b0, req_valid[0]};
    if (owner == 1) return {req_valid[1], 1'b0};
    if (req_valid == 2'b11) return pri ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  function automatic void rsp_cmp(int k, rsp_t it);
    chk($sformatf("rsp_route[%0d]", k), dut_rsp_valid[k], (it.id == 1) ? 2'b10 : 2'b01);
    chk($sformatf("rsp_cycle[%0d]", k), cyc, it.due);
    chk($sformatf("rsp_rdata[%0d]", k), dut_rdata[k], it.data);
    chk($sformatf("rsp_rparity[%0d]", k), dut_rpar[k], it.par);
    last_rsp[k] = dut_rdata[k];
  endfunction

  // response monitors, one per instance
  always @(negedge clk) begin
    if (dut_rsp_valid[0] != 2'b00) begin
      if (q0.size() == 0) chk("rsp_spurious[0]", dut_rsp_valid[0], 2'b00);
      else rsp_cmp(0, q0.pop_front());
    end else if (q0.size() != 0 && q0[0].due <= cyc) begin
      chk("rsp_missing[0]", dut_rsp_valid[0], (q0[0].id == 1) ? 2'b10 : 2'b01);
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dut_rsp_valid[1] != 2'b00) begin
      if (q1.size() == 0) chk("rsp_spurious[1]", dut_rsp_valid[1], 2'b00);
      else rsp_cmp(1, q1.pop_front());
    end else if (q1.size() != 0 && q1[0].due <= cyc) begin
      chk("rsp_missing[1]", dut_rsp_valid[1], (q1[0].id == 1) ? 2'b10 : 2'b01);
      void'(q1.pop_front());
    end
  end

  task automatic step();
    logic [1:0]  er, gr;
    int          id;
    logic [9:0]  a;
    logic        we;
    logic [3:0]  be, p;
    logic [31:0] d;
    @(negedge clk);
    er = exp_ready();
    last_addr = dut_addr[0];
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("req_ready[%0d]", k), dut_ready[k], er);
      chk($sformatf("ram_wen[%0d]", k), dut_wen[k], e_wen);
      chk($sformatf("ram_ren[%0d]", k), dut_ren[k], e_ren);
      chk($sformatf("ram_be[%0d]", k), dut_be[k], e_be);
      chk($sformatf("ram_addr[%0d]", k), dut_addr[k], e_addr);
      if (e_wen) begin
        chk($sformatf("ram_wdata[%0d]", k), dut_wdata[k], e_wdata);
        chk($sformatf("ram_wparity[%0d]", k), dut_wpar[k], e_wpar);
      end
      chk($sformatf("busy[%0d]", k), dut_busy[k],
          (owner >= 0 || cyc <= last_rd + 2 + k) ? 1'b1 : 1'b0);
    end
    gr = er & req_valid;
    @(posedge clk);
    cyc++;
    if (rst) begin
      owner = -1; pri = 1'b0; last_rd = -100;
      q0.delete(); q1.delete();
      e_wen = 0; e_ren = 0; e_be = 0; e_addr = 0; e_wdata = 0; e_wpar = 0;
      grant_log.push_back(-1);
    end else if (gr != 2'b00) begin
      id = gr[1] ? 1 : 0;
      a  = (id == 1) ? req_addr[19:10]     : req_addr[9:0];
      be = (id == 1) ? req_be[7:4]         : req_be[3:0];
      d  = (id == 1) ? req_wdata[63:32]    : req_wdata[31:0];
      p  = (id == 1) ? req_wparity[7:4]    : req_wparity[3:0];
      we = req_we[id];
      grant_log.push_back(id);
      pri   = (id == 0);
      owner = req_lock[id] ? id : -1;
      e_wen = we; e_ren = ~we; e_be = we ? be : 4'b0;
      e_addr = {a, 5'b0}; e_wdata = d; e_wpar = p;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            refmem[a][8*b +: 8] = d[8*b +: 8];
            refmem[a][32+b]     = p[b];
          end
        end
      end else begin
        last_rd = cyc - 1;
        q0.push_back('{id: id, due: cyc + 1, data: refmem[a][31:0], par: refmem[a][35:32]});
        q1.push_back('{id: id, due: cyc + 2, data: refmem[a][31:0], par: refmem[a][35:32]});
      end
    end else begin
      e_wen = 0; e_ren = 0; e_be = 0;
      grant_log.push_back(-1);
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [3:0] be0, input logic [3:0] be1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid   = v;
    req_we      = we;
    req_lock    = lk;
    req_addr    = {a1, a0};
    req_be      = {be1, be0};
    req_wdata   = {d1, d0};
    req_wparity = 8'($urandom);
  endtask

  task automatic check_log(string name, int exp[6]);
    chk({name, "_len"}, grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk($sformatf("%s[%0d]", name, i), grant_log[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 10'd0, 10'd0, 4'hF, 4'hF, 32'd0, 32'd0);
    #1;
    repeat (3) step();
    rst = 1'b0;

    // both requesters reading continuously, no lock: strict alternation
    grant_log.delete();
    drive(2'b11, 2'b00, 2'b00, 10'd1, 10'd2, 4'hF, 4'hF, 32'd0, 32'd0);
    repeat (6) step();
    check_log("alt_grants", exp_alt);
    drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 4'h0, 4'h0, 32'd0, 32'd0);
    repeat (4) step();

    // partial write merge at the top address
    drive(2'b01, 2'b01, 2'b00, 10'h3FF, 10'd0, 4'hF, 4'h0, 32'h11223344, 32'd0);
    step();
    drive(2'b01, 2'b01, 2'b00, 10'h3FF, 10'd0, 4'b0101, 4'h0, 32'hDEADBEEF, 32'd0);
    step();
    drive(2'b01, 2'b00, 2'b00, 10'h3FF, 10'd0, 4'hF, 4'h0, 32'd0, 32'd0);
    step();
    chk("addr_3ff", last_addr, 15'h7FE0);
    drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 4'h0, 4'h0, 32'd0, 32'd0);
    repeat (4) step();
    chk("merge_rdata[0]", last_rsp[0], 32'h11AD33EF);
    chk("merge_rdata[1]", last_rsp[1], 32'h11AD33EF);

    // requester 1 locks, then goes quiet while requester 0 waits
    grant_log.delete();
    drive(2'b10, 2'b00, 2'b10, 10'd5, 10'd6, 4'hF, 4'hF, 32'd0, 32'd0);
    step();
    drive(2'b01, 2'b00, 2'b00, 10'd5, 10'd6, 4'hF, 4'hF, 32'd0, 32'd0);
    repeat (3) step();
    drive(2'b11, 2'b00, 2'b00, 10'd5, 10'd6, 4'hF, 4'hF, 32'd0, 32'd0);
    step();
    drive(2'b01, 2'b00, 2'b00, 10'd5, 10'd6, 4'hF, 4'hF, 32'd0, 32'd0);
    step();
    check_log("lock_grants", exp_lock);
    drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 4'h0, 4'h0, 32'd0, 32'd0);
    repeat (4) step();

    // reset right behind a read accept drops the response and restores priority
    drive(2'b01, 2'b00, 2'b00, 10'd7, 10'd7, 4'hF, 4'hF, 32'd0, 32'd0);
    step();
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 10'd7, 10'd7, 4'hF, 4'hF, 32'd0, 32'd0);
    step();
    rst = 1'b0;
    grant_log.delete();
    step();
    chk("post_reset_grant", grant_log[0], 0);
    drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 4'h0, 4'h0, 32'd0, 32'd0);
    repeat (5) step();

    // randomized traffic on a small address set so read-after-write is frequent
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(2'($urandom), 2'($urandom),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
            10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)),
            4'($urandom), 4'($urandom), $urandom, $urandom);
      step();
    end

    rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 4'h0, 4'h0, 32'd0, 32'd0);
    repeat (8) step();
    chk("drain[0]", q0.size(), 0);
    chk("drain[1]", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram36k_port_arbiter.md
RAM36K_PORT_ARBITER -- requirements
Module: ram36k_port_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter READ_LATENCY SHALL have default 1 and SHALL be the number of CLK edges from the RAM sampling RAM_REN to RAM_RDATA being valid. Legal values are 1 and 2.
REQ-003 CLK  input  1  clock shared by the arbiter and the driven RAM port; all logic is rising-edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 REQ_VALID  input  2  per-requester command valid; bit i is requester i.
REQ-006 REQ_WE  input  2  per-requester command type: 1 = write, 0 = read.
REQ-007 REQ_LOCK  input  2  per-requester request to keep ownership after this command.
REQ-008 REQ_ADDR  input  20  word address; bits [10i+9:10i] belong to requester i.
REQ-009 REQ_BE  input  8  byte enables; bits [4i+3:4i] belong to requester i.
REQ-010 REQ_WDATA  input  64  write data; bits [32i+31:32i] belong to requester i.
REQ-011 REQ_WPARITY  input  8  write parity; bits [4i+3:4i] belong to requester i.
REQ-012 REQ_READY  output  2  command accepted when REQ_VALID[i] and REQ_READY[i] are both high.
REQ-013 RSP_VALID  output  2  read response strobe for requester i; cannot be backpressured.
REQ-014 RSP_RDATA, RSP_RPARITY  output  32, 4  read data and parity, shared by both requesters and qualified by RSP_VALID.
REQ-015 RAM_WEN, RAM_REN  output  1, 1  drive the RAM port WEN and REN.
REQ-016 RAM_ADDR  output  15  drives the RAM port ADDR in 36-bit mode.
REQ-017 RAM_BE, RAM_WDATA, RAM_WPARITY  output  4, 32, 4  drive the RAM port BE, WDATA and WPARITY.
REQ-018 RAM_RDATA, RAM_RPARITY  input  32, 4  from the RAM port RDATA and RPARITY.
REQ-019 BUSY  output  1  high when the FSM is not IDLE or any read is in flight.

Function
REQ-020 FSM states SHALL be IDLE, OWN0 and OWN1, and the block SHALL hold a 1-bit round-robin pointer PRI.
REQ-021 In IDLE, REQ_READY SHALL be combinational:
- If only one requester is valid, that requester is ready.
- If both are valid, requester PRI is ready.
- Never both ready in the same cycle.
REQ-022 In OWNi, REQ_READY[i] SHALL equal REQ_VALID[i], and the other requester's READY SHALL be 0, whether or not requester i is valid.
REQ-023 On an accept by requester i, PRI SHALL become ~i.
REQ-024 On an accept by requester i, the next FSM state SHALL be:
- OWNi if REQ_LOCK[i] = 1.
- IDLE if REQ_LOCK[i] = 0.
REQ-025 At most one command SHALL be accepted per cycle.
REQ-026 Accept in cycle c SHALL register the RAM command in cycle c+1:
- RAM_ADDR = {addr[9:0], 5'b0}.
- RAM_WEN = WE and RAM_REN = ~WE.
- Writes: RAM_BE = BE, with WDATA and WPARITY passed through.
- Reads: RAM_BE = 0.
REQ-027 In any cycle without an accept in the preceding cycle, RAM_WEN, RAM_REN and RAM_BE SHALL be 0; address and data outputs SHALL hold their last value.
REQ-028 A read accepted in cycle c SHALL assert RSP_VALID[i] for exactly one cycle, in cycle c+1+READ_LATENCY.
REQ-029 RSP_RDATA and RSP_RPARITY SHALL equal RAM_RDATA and RAM_RPARITY combinationally; their value is don't-care while RSP_VALID = 0.
REQ-030 Response routing SHALL use a tag shift register of depth 1+READ_LATENCY, holding a valid bit and a requester id per stage.
REQ-031 Responses SHALL return in acceptance order, with no loss at full throughput (one read accepted every cycle).
REQ-032 Writes SHALL produce no response.
REQ-033 Read-after-write to the same address from either requester SHALL return the new data when the read is accepted at least one cycle after the write; no further hazard logic is required.
REQ-034 REQ_READY SHALL NOT depend on RSP state; responses are never stalled.

Reset
REQ-035 While RST = 1, REQ_READY SHALL be 0.
REQ-036 On an edge with RST = 1, the block SHALL set:
- FSM = IDLE and PRI = 0.
- Tag pipeline cleared; in-flight reads are dropped and no RSP_VALID follows.
- RAM_WEN = RAM_REN = 0, RAM_BE = 0, RAM_ADDR = 0, RAM_WDATA = 0, RAM_WPARITY = 0.
- RSP_VALID = 0 and BUSY = 0.
REQ-037 RST asserted in OWNi SHALL release ownership; the first cycle after reset SHALL arbitrate from IDLE with PRI = 0.

Verification
REQ-038 Both requesters valid continuously with reads and no lock -> grants alternate 0,1,0,1 and RSP_VALID alternates bits in the same order, 2 cycles after each accept (READ_LATENCY = 1).
REQ-039 Requester 0 writes 0xDEADBEEF with BE = 4'b0101 to address 0x3FF, then reads it -> RAM_ADDR = 0x7FE0, and the RSP_RDATA bytes not enabled keep their prior value.
REQ-040 Requester 1 is accepted with LOCK = 1 and then drops VALID for 3 cycles while requester 0 is valid -> REQ_READY[0] stays 0 until requester 1 is accepted with LOCK = 0.
REQ-041 READ_LATENCY = 2 with back-to-back reads every cycle -> each RSP_VALID arrives 3 cycles after its accept, with no gaps and no misrouting.
REQ-042 RST pulsed 1 cycle after a read accept -> no RSP_VALID appears; after reset, requesters 0 and 1 both valid -> requester 0 is granted first.
